// File: rtl/luces_estela.sv
// Comet-tail LED driver: full brightness on sweep hit, stepped PWM fade after.
// Define LUCES_GAMMA_EN to square the brightness level for a perceptual fade.
module luces_estela #(
    parameter int PWM_BITS   = 4,
    parameter int DECAY_DIV  = 1000000,
    parameter int DECAY_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] leds_in,
    output logic [4:0] leds_out,
    output logic       active
);

    localparam int MAX = (1 << PWM_BITS) - 1;
    localparam int DW  = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;

    localparam logic [PWM_BITS-1:0] L_MAX  = PWM_BITS'(MAX);
    localparam logic [PWM_BITS-1:0] L_WRAP = PWM_BITS'(MAX - 1);
    localparam logic [DW-1:0]       D_LAST = DW'(DECAY_DIV - 1);
    localparam logic [PWM_BITS:0]   L_STEP = (PWM_BITS + 1)'(DECAY_STEP);

    logic [4:0]                r_in_q;
    logic [PWM_BITS-1:0]       r_pwm_cnt;
    logic [DW-1:0]             r_dcnt;
    logic [4:0][PWM_BITS-1:0]  r_level;

    logic                      w_tick;
    logic [4:0][PWM_BITS-1:0]  w_level_nxt;
    logic [4:0][PWM_BITS-1:0]  w_duty;
    logic [4:0][PWM_BITS:0]    w_diff;
    logic [4:0]                w_pwm_out;
    logic                      w_any;

    assign w_tick = (r_dcnt == D_LAST);

    always_comb begin
        w_level_nxt = '0;
        w_diff      = '0;
        for (int i = 0; i < 5; i++) begin
            w_diff[i] = {1'b0, r_level[i]} - L_STEP;
            if (!en) begin
                w_level_nxt[i] = '0;
            end else if (r_in_q[i]) begin
                w_level_nxt[i] = L_MAX;
            end else if (w_tick) begin
                // Borrow out of the extra bit means we would wrap: clamp to dark.
                w_level_nxt[i] = w_diff[i][PWM_BITS] ? '0
                               : w_diff[i][PWM_BITS-1:0];
            end else begin
                w_level_nxt[i] = r_level[i];
            end
        end
    end

`ifdef LUCES_GAMMA_EN
    logic [4:0][2*PWM_BITS-1:0] w_sq;

    always_comb begin
        w_sq   = '0;
        w_duty = '0;
        for (int i = 0; i < 5; i++) begin
            w_sq[i] = (2*PWM_BITS)'(r_level[i]) * (2*PWM_BITS)'(r_level[i]);
            w_duty[i] = (r_level[i] == L_MAX) ? L_MAX
                      : w_sq[i][2*PWM_BITS-1:PWM_BITS];
        end
    end
`else
    assign w_duty = r_level;
`endif

    always_comb begin
        w_pwm_out = '0;
        w_any     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_pwm_out[i] = (w_duty[i] > r_pwm_cnt);
            w_any        = w_any | (r_level[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_q    <= '0;
            r_pwm_cnt <= '0;
            r_dcnt    <= '0;
            r_level   <= '0;
            leds_out  <= '0;
            active    <= 1'b0;
        end else begin
            r_in_q   <= leds_in;
            r_level  <= w_level_nxt;
            leds_out <= w_pwm_out;
            active   <= w_any;
            if (!en) begin
                r_pwm_cnt <= '0;
                r_dcnt    <= '0;
            end else begin
                // Period of MAX cycles so level MAX is a solid 100% duty.
                r_pwm_cnt <= (r_pwm_cnt == L_WRAP) ? '0 : r_pwm_cnt + 1'b1;
                r_dcnt    <= w_tick ? '0 : r_dcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_luces_estela.sv
// Scoreboard bench for luces_estela: cycle-level reference model feeds a
// queue of expected outputs, a negedge monitor pops and compares.
module tb_luces_estela;

    localparam int PB   = 4;
    localparam int DIV  = 4;
    localparam int STEP = 4;
    localparam int MAX  = (1 << PB) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [4:0] leds_in = '0;
    logic [4:0] leds_out;
    logic       active;

    luces_estela #(
        .PWM_BITS  (PB),
        .DECAY_DIV (DIV),
        .DECAY_STEP(STEP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .leds_in (leds_in),
        .leds_out(leds_out),
        .active  (active)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pushes = 0;
    int pops = 0;
    logic [5:0] exp_q[$];

    int         m_lvl[5];
    int         m_n;
    logic [4:0] m_inq;

    function automatic int duty_of(input int l);
`ifdef LUCES_GAMMA_EN
        if (l == MAX) return MAX;
        return (l * l) / (1 << PB);
`else
        return l;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_lvl[i] = 0;
        m_n   = 0;
        m_inq = '0;
    endtask

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the coming edge.
    task automatic step(input logic e, input logic [4:0] li);
        logic [4:0] eo;
        logic       ea;
        bit         tick;
        en      = e;
        leds_in = li;
        eo = '0;
        ea = 1'b0;
        for (int i = 0; i < 5; i++) begin
            eo[i] = (duty_of(m_lvl[i]) > (m_n % MAX));
            if (m_lvl[i] != 0) ea = 1'b1;
        end
        exp_q.push_back({ea, eo});
        pushes++;
        if (e) begin
            tick = ((m_n % DIV) == DIV - 1);
            for (int i = 0; i < 5; i++) begin
                if (m_inq[i]) m_lvl[i] = MAX;
                else if (tick) m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
            end
            m_n++;
        end else begin
            for (int i = 0; i < 5; i++) m_lvl[i] = 0;
            m_n = 0;
        end
        m_inq = li;
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [5:0] e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pops++;
            vectors++;
            if ({active, leds_out} !== e) begin
                miscompares++;
                $display("FAIL out: got act=%b leds=%b want act=%b leds=%b at %0t",
                         active, leds_out, e[5], e[4:0], $time);
            end
        end
    end

    initial begin
        logic       e;
        logic [4:0] li;
        model_reset();
        #1;
        chk("reset_leds", int'(leds_out), 0);
        chk("reset_active", int'(active), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        repeat (10) step(1'b1, 5'b11111);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_leds", int'(leds_out), 0);
        chk("async_rst_active", int'(active), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        step(1'b1, 5'b00001);
        repeat (4) step(1'b1, 5'b00000);

        step(1'b1, 5'b10000);
        repeat (40) step(1'b1, 5'b00000);

        repeat (16) step(1'b1, 5'b00100);
        repeat (30) step(1'b1, 5'b00000);

        step(1'b1, 5'b01000);
        repeat (4) step(1'b1, 5'b00000);
        repeat (8) step(1'b0, 5'($urandom));
        step(1'b1, 5'b00000);
        step(1'b1, 5'b00010);
        repeat (30) step(1'b1, 5'b00000);

        repeat (1500) begin
            e  = ($urandom_range(0, 19) != 0);
            li = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
            step(e, li);
        end
        repeat (20) step(1'b1, 5'b00000);

        #3;
        chk("drain_pops", pops, pushes);
        chk("drain_queue", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
